// File: rtl/map_recover_ctrl.sv
// Map-table recovery sequencer: after a flush, copies the 32 committed arch-map tags into the
// speculative map table, one entry per cycle. Optional feature macro: MAP_RECOVER_SKIP_R0_EN.
package map_recover_pkg;
   typedef struct packed {
      logic [5:0] phys_reg;
      logic       ready;
      logic       spec;
   } tag_t;
endpackage

module map_recover_ctrl
   import map_recover_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       flush_req,
   output logic [4:0] arch_read_idx,
   input  tag_t       arch_read_out,
   output logic       mt_wr_en,
   output logic [4:0] mt_wr_idx,
   output tag_t       mt_wr_tag,
   output logic       dispatch_stall,
   output logic       retire_block,
   output logic       recover_done,
   output logic       busy
);
   typedef enum logic [1:0] {IDLE, DRAIN, COPY, DONE} state_t;

`ifdef MAP_RECOVER_SKIP_R0_EN
   localparam logic [4:0] FIRST_IDX = 5'd1;
`else
   localparam logic [4:0] FIRST_IDX = 5'd0;
`endif
   localparam logic [4:0] LAST_IDX = 5'd31;

   state_t     state_q;
   logic [4:0] cnt_q;
   logic       in_copy;

   // A flush arriving in COPY or DONE restarts the walk; one in DRAIN is already covered.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (flush_req) begin
                  state_q <= DRAIN;
                  cnt_q   <= '0;
               end
            end
            DRAIN: begin
               state_q <= COPY;
               cnt_q   <= FIRST_IDX;
            end
            COPY: begin
               if (flush_req) begin
                  state_q <= DRAIN;
                  cnt_q   <= '0;
               end else begin
                  if (cnt_q == LAST_IDX) begin
                     state_q <= DONE;
                  end
                  cnt_q <= cnt_q + 5'd1;
               end
            end
            DONE: begin
               if (flush_req) begin
                  state_q <= DRAIN;
                  cnt_q   <= '0;
               end else begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign in_copy = (state_q == COPY);

   // The write data is a pure pass-through of the arch map read port.
   assign arch_read_idx  = in_copy ? cnt_q : 5'd0;
   assign mt_wr_en       = in_copy;
   assign mt_wr_idx      = in_copy ? cnt_q : 5'd0;
   assign mt_wr_tag      = in_copy ? arch_read_out : tag_t'(8'd0);

   assign busy           = (state_q != IDLE);
   assign dispatch_stall = busy;
   assign retire_block   = busy;
   assign recover_done   = (state_q == DONE) && !flush_req;
endmodule

// File: doc/map_recover_ctrl.md
# map_recover_ctrl

Sequencer that rebuilds the speculative map table from the architectural map after a branch mispredict or exception retires. On a flush request it stalls dispatch, blocks further retirement, walks all 32 architectural registers through the arch map's single read port, and writes each committed tag into the map table, one entry per cycle. It sits between the ROB (flush source), the arch map (read port) and the map table (write port).

## Interface
- No parameters; register count fixed at 32, index width 5. TAG is the codebase's packed tag type (phys_reg field plus status bits).
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- flush_req  in  1  single-cycle pulse from ROB: mispredicted branch or exception retired this cycle
- arch_read_idx  out  5  arch map read index
- arch_read_out  in  TAG  arch map read data, combinational from arch_read_idx
- mt_wr_en  out  1  map table write enable
- mt_wr_idx  out  5  map table write index
- mt_wr_tag  out  TAG  map table write data
- dispatch_stall  out  1  hold dispatch/rename
- retire_block  out  1  suppress ROB retire_en to arch map
- recover_done  out  1  single-cycle pulse, map table consistent
- busy  out  1  recovery in progress

## Operation
- States: IDLE, DRAIN, COPY, DONE; 5-bit counter cnt.
- IDLE: on flush_req -> DRAIN, cnt<=0. Otherwise stay.
- DRAIN: one cycle; lets the flushing retire's arch map update land and ROB/RS squash complete. -> COPY.
- COPY: arch_read_idx=cnt; mt_wr_en=1, mt_wr_idx=cnt, mt_wr_tag=arch_read_out (pass-through, no register). cnt increments each cycle; when cnt==31 (or final index per Configuration) -> DONE.
- DONE: recover_done=1 for one cycle -> IDLE.
- dispatch_stall = retire_block = busy = (state != IDLE).
- arch_read_idx = 0 outside COPY; mt_wr_en=0, mt_wr_idx=0, mt_wr_tag=0 outside COPY.
- flush_req in DRAIN: ignored (already pending). flush_req in COPY or DONE: restart -> DRAIN, cnt<=0, recover_done suppressed that cycle.
- cnt 5-bit wraps naturally; terminal compare exact, never relies on wrap.

## Timing
- Reset: state=IDLE, cnt=0; all outputs 0.
- flush_req sampled high at edge of cycle t: DRAIN in t+1, COPY cycles t+2..t+33 (idx 0..31), DONE/recover_done in t+34, IDLE (stall low) in t+35.
- Total stall 34 cycles from the cycle after flush_req (33 with skip feature).
- Map table write takes effect at edge ending each COPY cycle.
- All control outputs decoded from registered state/cnt; mt_wr_tag is combinational from arch_read_out only.
- Reset mid-recovery: next cycle IDLE, all outputs 0, no recover_done.

## Configuration
- MAP_RECOVER_SKIP_R0_EN defined: COPY starts at cnt=1 (DRAIN loads cnt<=1), writes idx 1..31 only; r0 entry untouched; COPY is 31 cycles, recover_done at t+33.
- Undefined: all 32 entries 0..31 copied, timing as above.

## Test plan
- Reset: hold reset 2 cycles -> all outputs 0, busy=0; flush_req during reset ignored.
- Basic recovery: arch map preloaded reg i -> phys i+32, flush_req at t -> busy t+1..t+34, 32 writes idx 0..31 with phys 32..63 in t+2..t+33, recover_done only at t+34.
- Restart: flush_req again at t+10 (COPY, idx 8) -> DRAIN at t+11, writes restart at idx 0 at t+12, recover_done at t+44, no pulse at t+34.
- Flush in DRAIN: flush_req at t and t+1 -> identical to single flush, recover_done at t+34.
- Reset mid-COPY at t+20 -> t+21 IDLE, mt_wr_en=0, no recover_done; subsequent flush runs full 34-cycle sequence.
- MAP_RECOVER_SKIP_R0_EN: flush at t -> no write to idx 0, first write idx 1 at t+2, last idx 31 at t+32, recover_done at t+33.
